// File: rtl/pattern_memory.sv
// 64 x 4 register-file memory holding the Simon pattern sequence.
// One synchronous write port, one combinational read port; rst clears every entry.
module pattern_memory #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_en,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Reset wins over a write requested in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end else if (w_en) begin
      mem_d[w_addr] = w_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // No write-through: a same-address read shows old data until the edge.
  assign r_data = mem_q[r_addr];

endmodule

// File: tb/tb_pattern_memory.sv
// Self-checking bench for pattern_memory: directed scenarios followed by
// randomized traffic, compared against a plain array reference model.
module tb_pattern_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en;
  logic [5:0] r_addr;
  logic [5:0] w_addr;
  logic [3:0] w_data;
  logic [3:0] r_data;

  int checks = 0;
  int errors = 0;

  logic [3:0] ref_mem [64];

  always #5 clk = ~clk;

  pattern_memory #(
    .DATA_WIDTH(4),
    .ADDR_WIDTH(6),
    .DEPTH(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .r_addr(r_addr),
    .w_addr(w_addr),
    .w_data(w_data),
    .w_en(w_en),
    .r_data(r_data)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (r_addr=%0d)", tag, got, exp, r_addr);
    end
  endtask

  // Advance one clock; the model applies the same rules as the memory at the edge.
  task automatic cycle();
    if (rst) begin
      foreach (ref_mem[i]) ref_mem[i] = 4'h0;
    end else if (w_en) begin
      ref_mem[w_addr] = w_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [5:0] a, input logic [3:0] d);
    w_addr = a;
    w_data = d;
    w_en   = 1'b1;
    cycle();
    w_en   = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [5:0] a, input logic [3:0] exp);
    r_addr = a;
    #1;
    check(tag, r_data, exp);
  endtask

  initial begin
    rst    = 1'b1;
    w_en   = 1'b0;
    r_addr = '0;
    w_addr = '0;
    w_data = '0;
    foreach (ref_mem[i]) ref_mem[i] = 4'hx;
    cycle();
    cycle();
    rst = 1'b0;
    read_chk("reset_state_0", 6'd0, 4'h0);
    read_chk("reset_state_42", 6'd42, 4'h0);

    // Reset clear
    write(6'd0, 4'hF);
    write(6'd31, 4'hF);
    write(6'd63, 4'hF);
    read_chk("pre_clear_31", 6'd31, 4'hF);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    read_chk("clear_0", 6'd0, 4'h0);
    read_chk("clear_31", 6'd31, 4'h0);
    read_chk("clear_63", 6'd63, 4'h0);
    read_chk("clear_rand", 6'($urandom_range(0, 63)), 4'h0);

    // Write/read sweep
    for (int a = 0; a < 64; a++) write(6'(a), 4'(a % 16));
    for (int a = 0; a < 64; a++) read_chk("sweep", 6'(a), 4'(a % 16));

    // Write disable
    write(6'd5, 4'h2);
    w_addr = 6'd5;
    w_data = 4'h8;
    w_en   = 1'b0;
    repeat (3) cycle();
    read_chk("wr_disable", 6'd5, 4'h2);

    // Read-during-write at the same address; neighbour 11 holds 4'hB from sweep
    write(6'd10, 4'h1);
    r_addr = 6'd10;
    w_addr = 6'd10;
    w_data = 4'h4;
    w_en   = 1'b1;
    #1;
    check("rdw_before", r_data, 4'h1);
    cycle();
    w_en = 1'b0;
    check("rdw_after", r_data, 4'h4);
    r_addr = 6'd11;
    w_addr = 6'd10;
    w_data = 4'h6;
    w_en   = 1'b1;
    #1;
    check("indep_before", r_data, 4'hB);
    cycle();
    w_en = 1'b0;
    check("indep_after", r_data, 4'hB);
    read_chk("indep_written", 6'd10, 4'h6);

    // Back-to-back writes: last wins
    write(6'd20, 4'h3);
    write(6'd20, 4'h9);
    read_chk("last_wins", 6'd20, 4'h9);

    // Reset priority over write
    rst    = 1'b1;
    w_en   = 1'b1;
    w_addr = 6'd3;
    w_data = 4'h8;
    cycle();
    rst  = 1'b0;
    w_en = 1'b0;
    read_chk("rst_priority", 6'd3, 4'h0);
    read_chk("rst_wiped_20", 6'd20, 4'h0);

    // Simon sequence
    write(6'd1, 4'b0001);
    write(6'd2, 4'b0010);
    write(6'd3, 4'b0100);
    write(6'd4, 4'b1000);
    read_chk("simon_1", 6'd1, 4'b0001);
    read_chk("simon_2", 6'd2, 4'b0010);
    read_chk("simon_3", 6'd3, 4'b0100);
    read_chk("simon_4", 6'd4, 4'b1000);
    read_chk("simon_0", 6'd0, 4'h0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 59) == 0);
      w_en   = 1'($urandom);
      w_addr = 6'($urandom);
      w_data = 4'($urandom);
      r_addr = ($urandom_range(0, 3) == 0) ? w_addr : 6'($urandom);
      #1;
      check("rand_pre", r_data, ref_mem[r_addr]);
      cycle();
      check("rand_post", r_data, ref_mem[r_addr]);
    end
    rst  = 1'b0;
    w_en = 1'b0;
    for (int a = 0; a < 64; a++) read_chk("final_sweep", 6'(a), ref_mem[a]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
